dcache_dm: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache that acts as the responder for the CPU data-memory port (dmem_*). It serves word-granular, byte-enabled reads and writes from the core and issues 256-bit line transfers to physical memory on misses and dirty evictions. It sits between the core's data port and the memory arbiter or physical memory model.

---
 rtl/dcache_dm_pkg.sv | 19 +
 rtl/dcache_dm_if.sv | 35 +++
 rtl/dcache_dm_array.sv | 66 ++++++
 rtl/dcache_dm.sv | 124 ++++++++++++
 tb/tb_dcache_dm.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_dm_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Imported by the interface, the storage array and the cache top level.
package dcache_types;

    localparam int LINE_BITS      = 256;
    localparam int OFFSET_BITS    = 5;
    localparam int WORDS_PER_LINE = LINE_BITS / 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    function automatic int tag_width(input int s_index);
        return 32 - OFFSET_BITS - s_index;
    endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// CPU data port and physical-memory line port of the cache, bundled together.
// The cache uses the slave view; the core/memory environment uses the master view.
interface dcache_dm_if;
    import dcache_types::*;

    logic                 mem_read;
    logic                 mem_write;
    logic [3:0]           mem_byte_enable;
    logic [31:0]          mem_address;
    logic [31:0]          mem_wdata;
    logic                 mem_resp;
    logic [31:0]          mem_rdata;

    logic                 pmem_read;
    logic                 pmem_write;
    logic [31:0]          pmem_address;
    logic [LINE_BITS-1:0] pmem_wdata;
    logic [LINE_BITS-1:0] pmem_rdata;
    logic                 pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/dcache_dm_array.sv
// Flop-based per-set storage: valid, dirty, tag and one 256-bit line per set.
// One combinational read port; line fill, byte-masked word write and dirty clear.
module dcache_array
    import dcache_types::*;
#(
    parameter int S_INDEX = 4,
    localparam int TAG_W  = tag_width(S_INDEX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [S_INDEX-1:0]   i_index,
    output logic                 o_valid,
    output logic                 o_dirty,
    output logic [TAG_W-1:0]     o_tag,
    output logic [LINE_BITS-1:0] o_line,
    input  logic                 i_line_we,
    input  logic [TAG_W-1:0]     i_line_tag,
    input  logic [LINE_BITS-1:0] i_line_data,
    input  logic                 i_word_we,
    input  logic [2:0]           i_word_sel,
    input  logic [3:0]           i_word_be,
    input  logic [31:0]          i_word_data,
    input  logic                 i_dirty_clr
);
    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0]      r_valid;
    logic [SETS-1:0]      r_dirty;
    logic [TAG_W-1:0]     r_tag  [SETS];
    logic [LINE_BITS-1:0] r_data [SETS];

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_line  = r_data[i_index];

    // NOTE: sequential state is only ever assigned with <=, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_line_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_index] <= 1'b1;
        end else if (i_dirty_clr) begin
            r_dirty[i_index] <= 1'b0;
        end
    end

    // NOTE: tag and data storage carry no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_tag[i_index]  <= i_line_tag;
            r_data[i_index] <= i_line_data;
        end else if (i_word_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_word_be[b]) begin
                    r_data[i_index][i_word_sel*32 + b*8 +: 8] <= i_word_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-back, write-allocate L1 data cache: zero-wait hits,
// dirty-line writeback then line fill on a miss, re-evaluated as a hit afterwards.
module dcache_dm
    import dcache_types::*;
#(
    parameter int S_INDEX = 4
) (
    input  logic       clk,
    input  logic       rst,
    dcache_dm_if.slave io_bus
);
    localparam int TAG_W = tag_width(S_INDEX);

    state_t r_state;
    state_t w_next_state;

    logic [S_INDEX-1:0]   w_index;
    logic [TAG_W-1:0]     w_req_tag;
    logic [2:0]           w_word_sel;
    logic [1:0]           w_unused_byte_off;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_valid;
    logic                 w_dirty;
    logic [TAG_W-1:0]     w_tag;
    logic [LINE_BITS-1:0] w_line;
    logic                 w_line_we;
    logic                 w_word_we;
    logic                 w_dirty_clr;

    assign w_index           = io_bus.mem_address[S_INDEX+OFFSET_BITS-1:OFFSET_BITS];
    assign w_req_tag         = io_bus.mem_address[31:S_INDEX+OFFSET_BITS];
    assign w_word_sel        = io_bus.mem_address[OFFSET_BITS-1:2];
    assign w_unused_byte_off = io_bus.mem_address[1:0];

    assign w_req = io_bus.mem_read | io_bus.mem_write;
    assign w_hit = w_valid && (w_tag == w_req_tag);

    dcache_array #(.S_INDEX(S_INDEX)) u_array (
        .clk         (clk),
        .rst         (rst),
        .i_index     (w_index),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_tag),
        .o_line      (w_line),
        .i_line_we   (w_line_we),
        .i_line_tag  (w_req_tag),
        .i_line_data (io_bus.pmem_rdata),
        .i_word_we   (w_word_we),
        .i_word_sel  (w_word_sel),
        .i_word_be   (io_bus.mem_byte_enable),
        .i_word_data (io_bus.mem_wdata),
        .i_dirty_clr (w_dirty_clr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    w_next_state = (w_valid && w_dirty) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                if (io_bus.pmem_resp) w_next_state = FILL;
            end
            FILL: begin
                if (io_bus.pmem_resp) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Everything is gated by rst so outputs read as zero while reset is held;
    // pmem_read/pmem_write come straight from the state register, hence glitch-free.
    always_comb begin
        // NOTE: every output gets a default first, so no path through this block can infer a latch.
        io_bus.mem_resp     = 1'b0;
        io_bus.mem_rdata    = '0;
        io_bus.pmem_read    = 1'b0;
        io_bus.pmem_write   = 1'b0;
        io_bus.pmem_address = '0;
        io_bus.pmem_wdata   = '0;
        w_line_we           = 1'b0;
        w_word_we           = 1'b0;
        w_dirty_clr         = 1'b0;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    if (w_req && w_hit) begin
                        io_bus.mem_resp = 1'b1;
                        if (io_bus.mem_write) begin
                            w_word_we = 1'b1;
                        end else begin
                            io_bus.mem_rdata = w_line[w_word_sel*32 +: 32];
                        end
                    end
                end
                WRITEBACK: begin
                    io_bus.pmem_write   = 1'b1;
                    io_bus.pmem_address = {w_tag, w_index, {OFFSET_BITS{1'b0}}};
                    io_bus.pmem_wdata   = w_line;
                    w_dirty_clr         = io_bus.pmem_resp;
                end
                FILL: begin
                    io_bus.pmem_read    = 1'b1;
                    io_bus.pmem_address = {w_req_tag, w_index, {OFFSET_BITS{1'b0}}};
                    w_line_we           = io_bus.pmem_resp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed scenarios plus random traffic,
// compared cycle by cycle against a memory-level model of cache behaviour.
module tb_dcache_dm;
    import dcache_types::*;

    localparam int S_INDEX = 4;
    localparam int SETS    = 1 << S_INDEX;

    logic clk = 1'b0;
    logic rst;

    dcache_dm_if bus ();

    dcache_dm #(.S_INDEX(S_INDEX)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // pmem: physical memory contents; gmem: what the CPU must observe.
    logic [255:0] pmem [logic [31:0]];
    logic [255:0] gmem [logic [31:0]];
    bit           m_valid [SETS];
    bit           m_dirty [SETS];
    logic [22:0]  m_tag   [SETS];

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = {la[15:0] ^ 16'hC3A5, 16'(w * 16'h1111)};
        end
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        return pmem.exists(la) ? pmem[la] : init_line(la);
    endfunction

    function automatic logic [255:0] cpu_line(input logic [31:0] la);
        return gmem.exists(la) ? gmem[la] : mem_line(la);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        gmem.delete();
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.pmem_resp = 1'b0;
        #1;
        check("idle_ctrl", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b000);
        check("idle_addr", bus.pmem_address, 32'h0);
        check("idle_rdata", bus.mem_rdata, 32'h0);
        check("idle_wdata", bus.pmem_wdata, 256'h0);
    endtask

    // One CPU access, checked every cycle until its mem_resp; pmem answers after lat extra cycles.
    task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input int lat,
                          output logic [31:0] rdata, output bit wb_seen,
                          output bit fill_seen, output logic [255:0] wb_act);
        logic [31:0]  la      = {addr[31:5], 5'b0};
        logic [3:0]   sidx    = addr[8:5];
        int           s       = int'(addr[8:5]);
        logic [22:0]  tag     = addr[31:9];
        int           ws      = int'(addr[4:2]);
        bit           hit     = m_valid[s] && (m_tag[s] == tag);
        logic [31:0]  wb_addr;
        logic [255:0] line;
        wb_seen   = 1'b0;
        fill_seen = 1'b0;
        wb_act    = '0;
        @(negedge clk);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        #1;
        if (!hit) begin
            check("miss_idle_ctrl", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b000);
            if (m_valid[s] && m_dirty[s]) begin
                wb_seen = 1'b1;
                wb_addr = {m_tag[s], sidx, 5'b0};
                for (int c = 0; c <= lat; c++) begin
                    @(negedge clk);
                    bus.pmem_resp = (c == lat);
                    #1;
                    check("wb_ctrl", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b001);
                    check("wb_addr", bus.pmem_address, wb_addr);
                    check("wb_data", bus.pmem_wdata, cpu_line(wb_addr));
                    wb_act = bus.pmem_wdata;
                end
                pmem[wb_addr] = cpu_line(wb_addr);
                m_dirty[s]    = 1'b0;
            end
            fill_seen = 1'b1;
            for (int c = 0; c <= lat; c++) begin
                @(negedge clk);
                bus.pmem_resp  = (c == lat);
                bus.pmem_rdata = (c == lat) ? mem_line(la)
                                            : {8{$urandom()}};
                #1;
                check("fill_ctrl", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b010);
                check("fill_addr", bus.pmem_address, la);
            end
            m_valid[s] = 1'b1;
            m_tag[s]   = tag;
            m_dirty[s] = 1'b0;
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            #1;
        end
        check("resp_ctrl", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b100);
        rdata = bus.mem_rdata;
        line  = cpu_line(la);
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) line[ws*32 + b*8 +: 8] = wd[b*8 +: 8];
            end
            gmem[la]   = line;
            m_dirty[s] = 1'b1;
        end else begin
            check("read_data", rdata, line[ws*32 +: 32]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd;
        logic [255:0] wbl;
        logic [255:0] lit;
        bit           wbs;
        bit           fls;

        rst                 = 1'b0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 4'h0;
        bus.mem_address     = 32'h0;
        bus.mem_wdata       = 32'h0;
        bus.pmem_rdata      = '0;
        bus.pmem_resp       = 1'b0;
        model_reset();

        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_ctrl", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b000);
            check("reset_addr", bus.pmem_address, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        idle_cycle();

        // Cold read of 0x40 with a known line: words 0x1000_000w.
        for (int w = 0; w < 8; w++) lit[w*32 +: 32] = 32'h1000_0000 + w;
        pmem[32'h40] = lit;
        access(1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 3, rd, wbs, fls, wbl);
        check("cold_fill_seen", fls, 1'b1);
        check("cold_rdata", rd, 32'h1000_0000);
        access(1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 3, rd, wbs, fls, wbl);
        check("repeat_is_hit", fls, 1'b0);
        check("repeat_rdata", rd, 32'h1000_0000);

        // Byte-enabled write hit, then read back.
        access(1'b1, 1'b0, 32'h44, 4'b0101, 32'hAABB_CCDD, 0, rd, wbs, fls, wbl);
        access(1'b0, 1'b1, 32'h44, 4'h0, 32'h0, 0, rd, wbs, fls, wbl);
        check("byte_merge", rd, 32'h10BB_00DD);

        // Dirty conflict miss evicts the merged line.
        access(1'b0, 1'b1, 32'h240, 4'h0, 32'h0, 2, rd, wbs, fls, wbl);
        check("evict_wb_seen", wbs, 1'b1);
        check("evict_wb_word1", wbl[63:32], 32'h10BB_00DD);
        check("evict_wb_word0", wbl[31:0], 32'h1000_0000);

        // Clean conflict miss: fill only; memory now holds the merged word.
        access(1'b0, 1'b1, 32'h44, 4'h0, 32'h0, 1, rd, wbs, fls, wbl);
        check("clean_no_wb", wbs, 1'b0);
        check("clean_fill_seen", fls, 1'b1);
        check("clean_rdata", rd, 32'h10BB_00DD);

        // Read and write together on a hit behave as a write and dirty the line.
        access(1'b1, 1'b1, 32'h48, 4'b1111, 32'hDEAD_BEEF, 0, rd, wbs, fls, wbl);
        idle_cycle();
        access(1'b0, 1'b1, 32'h48, 4'h0, 32'h0, 0, rd, wbs, fls, wbl);
        check("rw_merge", rd, 32'hDEAD_BEEF);
        access(1'b0, 1'b1, 32'h248, 4'h0, 32'h0, 1, rd, wbs, fls, wbl);
        check("rw_set_dirty", wbs, 1'b1);

        // Reset asserted while a fill is outstanding.
        @(negedge clk);
        bus.mem_read    = 1'b1;
        bus.mem_write   = 1'b0;
        bus.mem_address = 32'h60;
        #1;
        check("rmf_miss", bus.mem_resp, 1'b0);
        @(negedge clk);
        #1;
        check("rmf_fill_req", {bus.pmem_read, bus.pmem_write}, 2'b10);
        check("rmf_fill_addr", bus.pmem_address, 32'h60);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rmf_in_reset", {bus.mem_resp, bus.pmem_read, bus.pmem_write}, 3'b000);
        check("rmf_addr_zero", bus.pmem_address, 32'h0);
        @(negedge clk);
        #1;
        check("rmf_after_reset", {bus.pmem_read, bus.pmem_write}, 2'b00);
        @(negedge clk);
        rst          = 1'b1;
        bus.mem_read = 1'b0;
        model_reset();
        idle_cycle();
        access(1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 2, rd, wbs, fls, wbl);
        check("post_reset_miss", fls, 1'b1);
        check("post_reset_rdata", rd, 32'h1000_0000);

        // Random traffic over four tags so conflicts and evictions are frequent.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            bit          w;
            bit          r;
            w = $urandom_range(0, 1) == 1;
            r = w ? ($urandom_range(0, 3) == 0) : 1'b1;
            a = {21'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, SETS - 1)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            access(w, r, a, 4'($urandom_range(0, 15)), $urandom(),
                   int'($urandom_range(0, 3)), rd, wbs, fls, wbl);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
